// File: rtl/pacman_move_checker_pkg.sv
// Shared definitions for the pacman move checker and its helpers.
// Holds the map geometry, coordinate widths, direction encodings,
// the wall-bit polarity and the checker FSM state encodings.
package pacman_move_checker_pkg;

    localparam int MAP_ROWS = 64;   // BRAM depth, one row per map line
    localparam int MAP_COLS = 80;   // valid columns, bits above are zero pad
    localparam int ROW_W    = 128;  // BRAM data width
    localparam int ADDR_W   = 6;    // row address width
    localparam int COL_W    = 7;    // column coordinate width
    localparam int READ_LAT = 1;    // BRAM address-to-data latency

    // A set map bit marks a wall.
    localparam logic WALL = 1'b1;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

endpackage

// File: rtl/pacman_move_checker_next_cell.sv
// pacman_next_cell: combinational neighbour-cell calculator, also used by
// the ghost logic.
// Ports:
//   x, y  : current cell
//   dir   : move direction (dir_e encoding)
//   tx, ty: target cell, horizontal moves wrap through the side tunnel
//   oob   : target leaves the map (top/bottom edge or bad source column)
// When oob is set, tx/ty are still kept inside the map so a careless
// consumer can never index the pad bits.
module pacman_next_cell
    import pacman_move_checker_pkg::*;
#(
    parameter int MAP_ROWS_P = MAP_ROWS,
    parameter int MAP_COLS_P = MAP_COLS,
    parameter int ADDR_W_P   = ADDR_W,
    parameter int COL_W_P    = COL_W
) (
    input  logic [COL_W_P-1:0]  x,
    input  logic [ADDR_W_P-1:0] y,
    input  logic [1:0]          dir,
    output logic [COL_W_P-1:0]  tx,
    output logic [ADDR_W_P-1:0] ty,
    output logic                oob
);

    localparam logic [COL_W_P-1:0]  LAST_X = COL_W_P'(MAP_COLS_P - 1);
    localparam logic [ADDR_W_P-1:0] LAST_Y = ADDR_W_P'(MAP_ROWS_P - 1);

    always_comb begin
        tx  = x;
        ty  = y;
        oob = (x > LAST_X);
        case (dir_e'(dir))
            DIR_UP: begin
                if (y == '0) oob = 1'b1;
                else         ty  = y - ADDR_W_P'(1);
            end
            DIR_DOWN: begin
                if (y == LAST_Y) oob = 1'b1;
                else             ty  = y + ADDR_W_P'(1);
            end
            DIR_RIGHT: tx = (x == LAST_X) ? '0 : x + COL_W_P'(1);
            DIR_LEFT:  tx = (x == '0) ? LAST_X : x - COL_W_P'(1);
            default: ;
        endcase
        // Bad source column: park the target on column 0.
        if (x > LAST_X) tx = '0;
    end

endmodule

// File: rtl/pacman_move_checker.sv
// pacman_move_checker: validates a pacman move against the map BRAM.
// A request (cell + direction) is turned into a target cell, the target
// row is read from the map memory and the wall bit decides grant/block.
// Ports:
//   clka, rst_n          : clock, async active-low reset
//   req_valid/ready      : request handshake; req_x/req_y/req_dir payload
//   rsp_valid/ready      : response handshake, response held until taken
//   rsp_blocked/x/y      : verdict and resulting position
//   mem_ena/addra/douta  : read port of the map BRAM
module pacman_move_checker
    import pacman_move_checker_pkg::*;
(
    input  logic              clka,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COL_W-1:0]  req_x,
    input  logic [ADDR_W-1:0] req_y,
    input  logic [1:0]        req_dir,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_blocked,
    output logic [COL_W-1:0]  rsp_x,
    output logic [ADDR_W-1:0] rsp_y,
    output logic              mem_ena,
    output logic [ADDR_W-1:0] mem_addra,
    input  logic [ROW_W-1:0]  mem_douta
);

    localparam int               LAT_W    = $clog2(READ_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

    state_e              state, state_nxt;
    logic [COL_W-1:0]    x_q, tx_q;
    logic [ADDR_W-1:0]   y_q;
    logic [LAT_W-1:0]    lat_cnt;
    logic [COL_W-1:0]    tx;
    logic [ADDR_W-1:0]   ty;
    logic                oob;
    logic                accept;
    logic                wall_hit;

    pacman_next_cell u_next_cell (
        .x   (req_x),
        .y   (req_y),
        .dir (req_dir),
        .tx  (tx),
        .ty  (ty),
        .oob (oob)
    );

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    // Decoded from state so an async reset drops the enable immediately.
    assign mem_ena   = (state == ST_ISSUE);
    assign accept    = req_valid && req_ready;
    // tx_q is always a valid column, so the pad bits are never selected.
    assign wall_hit  = (mem_douta[tx_q] == WALL);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = oob ? ST_RESP : ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_WAIT;
            ST_WAIT:    if (lat_cnt == LAT_LAST) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_RESP;
            ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            tx_q        <= '0;
            lat_cnt     <= '0;
            mem_addra   <= '0;
            rsp_blocked <= 1'b0;
            rsp_x       <= '0;
            rsp_y       <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                x_q  <= req_x;
                y_q  <= req_y;
                tx_q <= tx;
                if (oob) begin
                    // Refused without touching the BRAM.
                    rsp_blocked <= 1'b1;
                    rsp_x       <= req_x;
                    rsp_y       <= req_y;
                end else begin
                    // Held through WAIT/CAPTURE; doubles as the target row.
                    mem_addra <= ty;
                end
            end

            if (state == ST_ISSUE)     lat_cnt <= '0;
            else if (state == ST_WAIT) lat_cnt <= lat_cnt + LAT_W'(1);

            if (state == ST_CAPTURE) begin
                rsp_blocked <= wall_hit;
                rsp_x       <= wall_hit ? x_q : tx_q;
                rsp_y       <= wall_hit ? y_q : mem_addra;
            end
        end
    end

endmodule

// File: tb/tb_pacman_move_checker.sv
// Self-checking bench for pacman_move_checker. A behavioural map BRAM with
// a known wall layout feeds the DUT; a table of moves is applied in a loop
// and expected responses go through a scoreboard queue. Hand-written
// sequences cover backpressure and reset in the middle of a read.
module tb_pacman_move_checker;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [6:0]   req_x = '0;
    logic [5:0]   req_y = '0;
    logic [1:0]   req_dir = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_blocked;
    logic [6:0]   rsp_x;
    logic [5:0]   rsp_y;
    logic         mem_ena;
    logic [5:0]   mem_addra;
    logic [127:0] mem_douta = '0;

    logic [127:0] map_mem [64];

    always #5 clk = ~clk;

    pacman_move_checker dut (
        .clka        (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_dir     (req_dir),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_blocked (rsp_blocked),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .mem_ena     (mem_ena),
        .mem_addra   (mem_addra),
        .mem_douta   (mem_douta)
    );

    // Map BRAM, one cycle read latency.
    always @(posedge clk) if (mem_ena) mem_douta <= map_mem[mem_addra];

    int ena_cnt  = 0;
    int ena_addr = -1;
    always @(negedge clk) if (mem_ena) begin
        ena_cnt  = ena_cnt + 1;
        ena_addr = int'(mem_addra);
    end

    typedef struct {
        logic [6:0] x;
        logic [5:0] y;
        logic [1:0] dir;
        logic       oob;
        logic       blk;
        logic [6:0] ex;
        logic [5:0] ey;
        logic [5:0] addr;
    } vec_t;

    typedef struct packed {
        logic       blk;
        logic [6:0] x;
        logic [5:0] y;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[12];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Negedge samples until rsp_valid: out-of-bounds answers on the first,
    // in-bounds goes ISSUE, WAIT, CAPTURE and answers on the fourth.
    localparam int LAT_OOB = 1;
    localparam int LAT_IN  = 4;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic issue(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", int'(req_ready), 1);
        req_x     = v.x;
        req_y     = v.y;
        req_dir   = v.dir;
        req_valid = 1'b1;
        ena_cnt   = 0;
        ena_addr  = -1;
        sb.push_back('{blk: v.blk, x: v.ex, y: v.ey});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 20);
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"},   int'(rsp_valid),   1);
            chk({tag, "_blocked"}, int'(rsp_blocked), int'(e.blk));
            chk({tag, "_x"},       int'(rsp_x),       int'(e.x));
            chk({tag, "_y"},       int'(rsp_y),       int'(e.y));
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    cyc;
        string tag;
        tag = $sformatf("vec%0d", idx);
        issue(v);
        wait_rsp(cyc);
        chk({tag, "_latency"}, cyc, v.oob ? LAT_OOB : LAT_IN);
        chk({tag, "_ena_pulses"}, ena_cnt, v.oob ? 0 : 1);
        if (!v.oob) chk({tag, "_addr"}, ena_addr, int'(v.addr));
        check_rsp(tag);
        @(negedge clk);
        chk({tag, "_rsp_drop"}, int'(rsp_valid), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int   cyc;
        int   seen;
        vec_t v;

        for (int r = 0; r < 64; r++) map_mem[r] = '0;
        map_mem[10][5]  = 1'b1;
        map_mem[20][79] = 1'b1;

        //          x     y     dir  oob   blk   ex    ey    addr
        vecs[0]  = '{7'd4,  6'd10, 2'd1, 1'b0, 1'b1, 7'd4,  6'd10, 6'd10};
        vecs[1]  = '{7'd4,  6'd10, 2'd3, 1'b0, 1'b0, 7'd3,  6'd10, 6'd10};
        vecs[2]  = '{7'd79, 6'd20, 2'd1, 1'b0, 1'b0, 7'd0,  6'd20, 6'd20};
        vecs[3]  = '{7'd0,  6'd20, 2'd3, 1'b0, 1'b1, 7'd0,  6'd20, 6'd20};
        vecs[4]  = '{7'd10, 6'd0,  2'd0, 1'b1, 1'b1, 7'd10, 6'd0,  6'd0};
        vecs[5]  = '{7'd10, 6'd63, 2'd2, 1'b1, 1'b1, 7'd10, 6'd63, 6'd0};
        vecs[6]  = '{7'd85, 6'd5,  2'd1, 1'b1, 1'b1, 7'd85, 6'd5,  6'd0};
        vecs[7]  = '{7'd5,  6'd11, 2'd0, 1'b0, 1'b1, 7'd5,  6'd11, 6'd10};
        vecs[8]  = '{7'd5,  6'd9,  2'd2, 1'b0, 1'b1, 7'd5,  6'd9,  6'd10};
        vecs[9]  = '{7'd6,  6'd10, 2'd3, 1'b0, 1'b1, 7'd6,  6'd10, 6'd10};
        vecs[10] = '{7'd40, 6'd63, 2'd0, 1'b0, 1'b0, 7'd40, 6'd62, 6'd62};
        vecs[11] = '{7'd0,  6'd0,  2'd2, 1'b0, 1'b0, 7'd0,  6'd1,  6'd1};

        // Reset state
        #12;
        chk("rst_rsp_valid",   int'(rsp_valid),   0);
        chk("rst_rsp_blocked", int'(rsp_blocked), 0);
        chk("rst_rsp_x",       int'(rsp_x),       0);
        chk("rst_rsp_y",       int'(rsp_y),       0);
        chk("rst_mem_ena",     int'(mem_ena),     0);
        chk("rst_mem_addra",   int'(mem_addra),   0);
        chk("rst_req_ready",   int'(req_ready),   1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Backpressure: response held, new requests ignored while busy.
        rsp_ready = 1'b0;
        v = vecs[1];
        issue(v);
        wait_rsp(cyc);
        chk("bp_latency", cyc, LAT_IN);
        req_x     = 7'd10;
        req_y     = 6'd0;
        req_dir   = 2'd0;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_held", int'(rsp_valid),   1);
            chk("bp_req_ready",  int'(req_ready),   0);
            chk("bp_blocked",    int'(rsp_blocked), 0);
            chk("bp_x",          int'(rsp_x),       3);
            chk("bp_y",          int'(rsp_y),       10);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check_rsp("bp");
        @(negedge clk);
        chk("bp_idle_ready", int'(req_ready), 1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_ena) seen++;
        end
        chk("bp_ignored_not_queued", seen, 0);

        // Reset during ISSUE: enable must drop without waiting for a clock.
        issue(vecs[2]);
        chk("rst_issue_ena_before", int'(mem_ena), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_issue_ena_after", int'(mem_ena), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during WAIT: aborted, no stale response afterwards.
        issue(vecs[11]);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_rsp_valid", int'(rsp_valid), 0);
        chk("rst_wait_mem_ena",   int'(mem_ena),   0);
        chk("rst_wait_req_ready", int'(req_ready), 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", int'(req_ready), 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_ena) seen++;
        end
        chk("post_rst_no_stale", seen, 0);

        // Checker still works after the aborted request.
        run_vec(vecs[3], 12);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
